// File: rtl/transpose_pingpong.sv
// Double-buffered tile transpose with per-tile bypass.
// One bank fills while the other drains, so streaming runs at one beat per cycle.
module transpose_pingpong #(
  parameter int ROW_DIM    = 16,
  parameter int COL_DIM    = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(ROW_DIM):0]      cfg_rows,
  input  logic [$clog2(COL_DIM):0]      cfg_cols,
  input  logic                          cfg_bypass,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COL_DIM*DATA_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROW_DIM*DATA_WIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          busy
);

  localparam int RW = $clog2(ROW_DIM) + 1;
  localparam int CW = $clog2(COL_DIM) + 1;
  localparam int NW = (RW > CW) ? RW : CW;
  localparam int RI = RW - 1;
  localparam int CI = CW - 1;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_t;

  bank_st_t st_q [2];
  bank_st_t st_d [2];
  logic wp_q, wp_d, rp_q, rp_d;
  logic [NW-1:0] wc_q, wc_d, rc_q, rc_d;

  logic [NW-1:0] rows_q [2];
  logic [NW-1:0] cols_q [2];
  logic          byp_q  [2];
  logic [DATA_WIDTH-1:0] mem [2][ROW_DIM][COL_DIM];

  logic [NW-1:0] r_cfg, c_cfg, r_wr, c_wr, n_rd;
  logic first_beat, wr_fire, wr_last, rd_fire;

  assign r_cfg = (cfg_rows == '0 || cfg_rows > RW'(ROW_DIM))
               ? NW'(ROW_DIM) : NW'(cfg_rows);
  assign c_cfg = (cfg_cols == '0 || cfg_cols > CW'(COL_DIM))
               ? NW'(COL_DIM) : NW'(cfg_cols);

  // Config is live only on a tile's first beat, latched thereafter.
  assign first_beat = (wc_q == '0);
  assign r_wr = first_beat ? r_cfg : rows_q[wp_q];
  assign c_wr = first_beat ? c_cfg : cols_q[wp_q];

  assign in_ready = !reset &&
    (st_q[wp_q] == EMPTY || st_q[wp_q] == FILLING);
  assign wr_fire = in_valid && in_ready;
  assign wr_last = (wc_q == r_wr - NW'(1));

  assign out_valid = !reset &&
    (st_q[rp_q] == FULL || st_q[rp_q] == DRAINING);
  assign n_rd = byp_q[rp_q] ? rows_q[rp_q] : cols_q[rp_q];
  assign out_last = out_valid && (rc_q == n_rd - NW'(1));
  assign rd_fire = out_valid && out_ready;

  assign busy = !reset && (st_q[0] != EMPTY || st_q[1] != EMPTY);

  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    wp_d = wp_q;
    rp_d = rp_q;
    wc_d = wc_q;
    rc_d = rc_q;
    if (wr_fire) begin
      wc_d = wr_last ? '0 : wc_q + NW'(1);
      wp_d = wr_last ? !wp_q : wp_q;
    end
    if (rd_fire) begin
      rc_d = out_last ? '0 : rc_q + NW'(1);
      rp_d = out_last ? !rp_q : rp_q;
    end
    for (int b = 0; b < 2; b++) begin
      if (wr_fire && wp_q == 1'(b))
        st_d[b] = wr_last ? FULL : FILLING;
      if (rd_fire && rp_q == 1'(b))
        st_d[b] = out_last ? EMPTY : DRAINING;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      wc_q <= '0;
      rc_q <= '0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      wp_q <= wp_d;
      rp_q <= rp_d;
      wc_q <= wc_d;
      rc_q <= rc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (first_beat) begin
        rows_q[wp_q] <= r_cfg;
        cols_q[wp_q] <= c_cfg;
        byp_q[wp_q]  <= cfg_bypass;
      end
      for (int j = 0; j < COL_DIM; j++)
        if (NW'(j) < c_wr)
          mem[wp_q][wc_q[RI-1:0]][j] <=
            in_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar i = 0; i < ROW_DIM; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] tv, bv;
    assign tv = (NW'(i) < rows_q[rp_q])
              ? mem[rp_q][i][rc_q[CI-1:0]] : '0;
    if (i < COL_DIM) begin : g_byp
      assign bv = (NW'(i) < cols_q[rp_q])
                ? mem[rp_q][rc_q[RI-1:0]][i] : '0;
    end else begin : g_nobyp
      assign bv = '0;
    end
    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] =
      !out_valid ? '0 : (byp_q[rp_q] ? bv : tv);
  end

endmodule
